// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory and decode.
// master = fetch unit, slave = memory/decode/redirect environment.
`timescale 1ns/1ps
interface fetch_unit_if;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output mem_req_valid, mem_req_addr, instr_valid, instr_data, instr_pc,
      input  mem_req_ready, mem_resp_valid, mem_resp_data, instr_ready,
             redirect_valid, redirect_pc
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, instr_valid, instr_data, instr_pc,
      output mem_req_ready, mem_resp_valid, mem_resp_data, instr_ready,
             redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Sequential instruction prefetcher: issues word fetches, buffers up to DEPTH
// in-flight/returned instructions and flushes on redirect, dropping stale responses.
`timescale 1ns/1ps
module fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h8000_0000,
   parameter int          DEPTH   = 4
) (
   input  logic            clk,
   input  logic            rst,
   fetch_unit_if.master    bus_io
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
      logic        filled;
   } entry_t;

   entry_t      q_q [DEPTH];
   entry_t      head;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   ptr_t        alloc_ptr_q, alloc_ptr_d;
   ptr_t        fill_ptr_q, fill_ptr_d;
   ptr_t        head_ptr_q, head_ptr_d;
   cnt_t        count_q, count_d;
   cnt_t        drop_q, drop_d;
   cnt_t        pend_q, pend_d;   // allocated entries still waiting for data

   logic req_hs, resp_fill, resp_drop, pop_hs, redirect;
   logic unused_pc_bits;

   assign unused_pc_bits = ^bus_io.redirect_pc[1:0];

   assign head                 = q_q[head_ptr_q];
   assign bus_io.mem_req_valid = !rst && (({1'b0, count_q} + {1'b0, drop_q}) < DEPTH_W);
   assign bus_io.mem_req_addr  = fetch_pc_q;
   assign bus_io.instr_valid   = (count_q != '0) && head.filled;
   assign bus_io.instr_data    = head.data;
   assign bus_io.instr_pc      = head.pc;

   assign req_hs    = bus_io.mem_req_valid && bus_io.mem_req_ready;
   assign resp_drop = bus_io.mem_resp_valid && (drop_q != '0);
   assign resp_fill = bus_io.mem_resp_valid && (drop_q == '0);
   assign pop_hs    = bus_io.instr_valid && bus_io.instr_ready;
   assign redirect  = bus_io.redirect_valid;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      alloc_ptr_d = alloc_ptr_q;
      fill_ptr_d  = fill_ptr_q;
      head_ptr_d  = head_ptr_q;
      count_d     = count_q;
      drop_d      = drop_q;
      pend_d      = pend_q;
      if (redirect) begin
         fetch_pc_d  = {bus_io.redirect_pc[31:2], 2'b00};
         alloc_ptr_d = '0;
         fill_ptr_d  = '0;
         head_ptr_d  = '0;
         count_d     = '0;
         pend_d      = '0;
         // Everything still owed by memory becomes a response to discard.
         drop_d      = drop_q + pend_q + cnt_t'(req_hs) - cnt_t'(bus_io.mem_resp_valid);
      end else begin
         if (req_hs) begin
            fetch_pc_d  = fetch_pc_q + 32'd4;
            alloc_ptr_d = alloc_ptr_q + ptr_t'(1);
         end
         if (resp_fill) fill_ptr_d = fill_ptr_q + ptr_t'(1);
         if (pop_hs)    head_ptr_d = head_ptr_q + ptr_t'(1);
         count_d = count_q + cnt_t'(req_hs) - cnt_t'(pop_hs);
         pend_d  = pend_q + cnt_t'(req_hs) - cnt_t'(resp_fill);
         drop_d  = drop_q - cnt_t'(resp_drop);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers
   // update together from values sampled at the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q  <= PC_INIT;
         alloc_ptr_q <= '0;
         fill_ptr_q  <= '0;
         head_ptr_q  <= '0;
         count_q     <= '0;
         drop_q      <= '0;
         pend_q      <= '0;
         // NOTE: the queue is tiny and its head drives outputs with defined reset
         // values, so its storage is reset like ordinary flops.
         for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         alloc_ptr_q <= alloc_ptr_d;
         fill_ptr_q  <= fill_ptr_d;
         head_ptr_q  <= head_ptr_d;
         count_q     <= count_d;
         drop_q      <= drop_d;
         pend_q      <= pend_d;
         if (redirect) begin
            for (int i = 0; i < DEPTH; i++) q_q[i].filled <= 1'b0;
         end else begin
            if (req_hs) begin
               q_q[alloc_ptr_q].pc     <= fetch_pc_q;
               q_q[alloc_ptr_q].filled <= 1'b0;
            end
            if (resp_fill) begin
               q_q[fill_ptr_q].data   <= bus_io.mem_resp_data;
               q_q[fill_ptr_q].filled <= 1'b1;
            end
            if (pop_hs) q_q[head_ptr_q].filled <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected PCs, a
// monitor checks every decode handshake, a small memory model answers fetches.
`timescale 1ns/1ps
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   fetch_unit_if bus ();

   fetch_unit #(.PC_INIT(32'h8000_0000), .DEPTH(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat = 1;
   int outstanding = 0;
   logic [31:0] sb [$];

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;
   mreq_t mq [$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return {a[15:0], ~a[31:16]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: in-order responses, each one `lat` cycles after its request.
   initial begin
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mq.delete();
            outstanding = 0;
         end else begin
            if (bus.mem_resp_valid) begin
               if (outstanding == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL resp_without_req: got response with %0d outstanding expected >0", outstanding);
               end else outstanding--;
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
               mq.push_back('{addr: bus.mem_req_addr, due: cyc + lat});
               outstanding++;
            end
         end
         @(posedge clk);
         #1;
         if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = mdata(mq[0].addr);
            void'(mq.pop_front());
         end else begin
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = '0;
         end
      end
   end

   // Monitor: every decode handshake must match the next expected PC.
   initial begin
      logic [31:0] exp_pc;
      forever begin
         @(negedge clk);
         if (!rst && bus.instr_valid && bus.instr_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pop: got pc %h expected no instruction", bus.instr_pc);
            end else begin
               exp_pc = sb.pop_front();
               check("instr_pc", bus.instr_pc, exp_pc);
               check("instr_data", bus.instr_data, mdata(exp_pc));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected finish before 100us");
      $fatal(1);
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
      check({tag, "_req_addr"}, bus.mem_req_addr, 32'h8000_0000);
      check({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
      check({tag, "_instr_data"}, bus.instr_data, 32'd0);
      check({tag, "_instr_pc"}, bus.instr_pc, 32'd0);
   endtask

   task automatic reset_and_release(input int new_lat, input logic ready);
      @(posedge clk);
      #2 rst = 1'b1;
      lat = new_lat;
      bus.instr_ready = ready;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic push4(input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [31:0] a3);
      sb.push_back(a0);
      sb.push_back(a1);
      sb.push_back(a2);
      sb.push_back(a3);
   endtask

   // Queue must be full with four filled entries: exactly four pops follow.
   task automatic drain4(input string tag);
      @(negedge clk);
      check({tag, "_full_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
      check({tag, "_full_instr_valid"}, 32'(bus.instr_valid), 32'd1);
      @(posedge clk);
      #2 bus.instr_ready = 1'b1;
      repeat (4) @(posedge clk);
      #2 bus.instr_ready = 1'b0;
      @(negedge clk);
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int n_acc;
      bus.mem_req_ready  = 1'b1;
      bus.instr_ready    = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");

      // Back-to-back stream at latency 1.
      for (int i = 0; i < 8; i++) sb.push_back(32'h8000_0000 + 32'(4 * i));
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("first_req_valid", 32'(bus.mem_req_valid), 32'd1);
      check("first_req_addr", bus.mem_req_addr, 32'h8000_0000);
      @(posedge clk);
      @(negedge clk);
      check("second_req_addr", bus.mem_req_addr, 32'h8000_0004);
      check("not_yet_valid", 32'(bus.instr_valid), 32'd0);
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("stream_instr_valid", 32'(bus.instr_valid), 32'd1);
         check("stream_req_addr", bus.mem_req_addr, 32'h8000_0000 + 32'(4 * (i + 2)));
         @(posedge clk);
      end
      #2 bus.instr_ready = 1'b0;
      check("stream_sb_empty", 32'(sb.size()), 32'd0);

      // Reset mid-stream with fetches still in flight.
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midrst");

      // Decode stalled: exactly DEPTH requests, then resume at +0x10.
      reset_and_release(1, 1'b0);
      @(negedge clk);
      check("restart_req_addr", bus.mem_req_addr, 32'h8000_0000);
      n_acc = (bus.mem_req_valid && bus.mem_req_ready) ? 1 : 0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         if (bus.mem_req_valid && bus.mem_req_ready) n_acc++;
      end
      check("stall_accepted", 32'(n_acc), 32'd4);
      check("stall_req_valid", 32'(bus.mem_req_valid), 32'd0);
      push4(32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C);
      @(posedge clk);
      #2 bus.instr_ready = 1'b1;
      @(negedge clk);
      check("full_before_pop", 32'(bus.mem_req_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("resume_req_valid", 32'(bus.mem_req_valid), 32'd1);
      check("resume_req_addr", bus.mem_req_addr, 32'h8000_0010);
      repeat (3) @(posedge clk);
      #2 bus.instr_ready = 1'b0;
      @(negedge clk);
      check("stall_sb_empty", 32'(sb.size()), 32'd0);

      // Latency 3, three in flight, redirect to an unaligned address.
      reset_and_release(3, 1'b0);
      repeat (2) @(posedge clk);
      #2 bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h8000_0103;
      @(posedge clk);
      #2 bus.redirect_valid = 1'b0;
      @(negedge clk);
      check("redir_req_addr", bus.mem_req_addr, 32'h8000_0100);
      check("redir_req_valid", 32'(bus.mem_req_valid), 32'd1);
      check("redir_instr_valid", 32'(bus.instr_valid), 32'd0);
      repeat (20) @(posedge clk);
      push4(32'h8000_0100, 32'h8000_0104, 32'h8000_0108, 32'h8000_010C);
      drain4("redir");

      // Redirect coinciding with a request handshake and a response.
      reset_and_release(2, 1'b0);
      repeat (2) @(posedge clk);
      #2 bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h8000_0200;
      @(negedge clk);
      check("coinc_resp_valid", 32'(bus.mem_resp_valid), 32'd1);
      check("coinc_req_valid", 32'(bus.mem_req_valid), 32'd1);
      @(posedge clk);
      #2 bus.redirect_valid = 1'b0;
      @(negedge clk);
      check("coinc_req_addr", bus.mem_req_addr, 32'h8000_0200);
      check("coinc_instr_valid", 32'(bus.instr_valid), 32'd0);
      repeat (12) @(posedge clk);
      push4(32'h8000_0200, 32'h8000_0204, 32'h8000_0208, 32'h8000_020C);
      drain4("coinc");

      // Redirect with a pop in the same cycle, then address wrap.
      reset_and_release(1, 1'b0);
      repeat (10) @(posedge clk);
      sb.push_back(32'h8000_0000);
      #2 bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFC;
      bus.instr_ready = 1'b1;
      @(posedge clk);
      #2 bus.redirect_valid = 1'b0;
      bus.instr_ready = 1'b0;
      @(negedge clk);
      check("wrap_instr_valid", 32'(bus.instr_valid), 32'd0);
      check("wrap_req_valid", 32'(bus.mem_req_valid), 32'd1);
      check("wrap_req_addr0", bus.mem_req_addr, 32'hFFFF_FFFC);
      @(posedge clk);
      @(negedge clk);
      check("wrap_req_addr1", bus.mem_req_addr, 32'h0000_0000);
      check("wrap_pop_sb_empty", 32'(sb.size()), 32'd0);
      repeat (10) @(posedge clk);
      push4(32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008);
      drain4("wrap");

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
